// File: rtl/inv_permute_buffer.sv
// inv_permute_buffer: collects a 16-word block, then replays it in inverse
// Threefish-1024 permutation order (output word j = input word INV[j]).
//
// Ports:
//   clk_i        single clock, rising-edge
//   rst_i        synchronous active-high reset
//   dir_i        (only with INV_PERMUTE_FWD_EN) 1 = forward PI, 0 = INV;
//                sampled at the first input handshake of each block
//   in_valid_i   input word offered
//   in_ready_o   high in LOAD; word accepted when valid and ready both high
//   in_word_i    permuted-domain word, arriving in index order 0..15
//   out_valid_o  high in DRAIN
//   out_ready_i  output word consumed when valid and ready both high
//   out_word_o   unpermuted word (zero when out_valid_o is low)
//   out_idx_o    index of the word on out_word_o (zero when out_valid_o is low)
//
// Optional feature macro: INV_PERMUTE_FWD_EN adds dir_i and the forward table.
module inv_permute_buffer #(
  parameter int unsigned WORD_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
`ifdef INV_PERMUTE_FWD_EN
  input  logic              dir_i,
`endif
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WORD_W-1:0] in_word_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WORD_W-1:0] out_word_o,
  output logic [3:0]        out_idx_o
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned DEPTH = 16;

  typedef enum logic {ST_LOAD, ST_DRAIN} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_count;
  logic [WORD_W-1:0]  r_buf [DEPTH];
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WORD_W-1:0]  r_out_word;
  logic [IDX_W-1:0]   r_out_idx;

  logic               w_dir;
  logic               w_in_fire;
  logic [IDX_W-1:0]   w_next_count;
  logic [IDX_W-1:0]   w_rd_sel;

  // Output slot j reads buffer word map(j); fwd selects PI instead of INV.
  function automatic logic [3:0] f_map(input logic [3:0] j, input logic fwd);
    logic [3:0] r;
    r = j;
    if (fwd) begin
      case (j)
        4'd0:  r = 4'd0;
        4'd1:  r = 4'd9;
        4'd2:  r = 4'd2;
        4'd3:  r = 4'd13;
        4'd4:  r = 4'd6;
        4'd5:  r = 4'd11;
        4'd6:  r = 4'd4;
        4'd7:  r = 4'd15;
        4'd8:  r = 4'd10;
        4'd9:  r = 4'd7;
        4'd10: r = 4'd12;
        4'd11: r = 4'd3;
        4'd12: r = 4'd14;
        4'd13: r = 4'd5;
        4'd14: r = 4'd8;
        default: r = 4'd1;
      endcase
    end else begin
      case (j)
        4'd0:  r = 4'd0;
        4'd1:  r = 4'd15;
        4'd2:  r = 4'd2;
        4'd3:  r = 4'd11;
        4'd4:  r = 4'd6;
        4'd5:  r = 4'd13;
        4'd6:  r = 4'd4;
        4'd7:  r = 4'd9;
        4'd8:  r = 4'd14;
        4'd9:  r = 4'd1;
        4'd10: r = 4'd8;
        4'd11: r = 4'd5;
        4'd12: r = 4'd10;
        4'd13: r = 4'd3;
        4'd14: r = 4'd12;
        default: r = 4'd7;
      endcase
    end
    return r;
  endfunction

`ifdef INV_PERMUTE_FWD_EN
  logic r_dir;

  // Direction is latched on the first word of a block and held until the next.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_dir <= 1'b0;
    end else if (r_state == ST_LOAD && in_valid_i && r_count == IDX_W'(0)) begin
      r_dir <= dir_i;
    end
  end

  assign w_dir = r_dir;
`else
  assign w_dir = 1'b0;
`endif

  assign w_in_fire    = !rst_i && (r_state == ST_LOAD) && in_valid_i;
  // Count+1 wraps to 0 on the 16th write, so this is also the first drain slot.
  assign w_next_count = r_count + IDX_W'(1);
  assign w_rd_sel     = f_map(w_next_count, w_dir);

  // Data buffer: no reset, stale words are unreachable until 16 fresh writes.
  always_ff @(posedge clk_i) begin
    if (w_in_fire) begin
      r_buf[r_count] <= in_word_i;
    end
  end

  // Control FSM with registered handshake and data outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_LOAD;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_word  <= '0;
      r_out_idx   <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (in_valid_i) begin
            r_count <= w_next_count;
            if (r_count == IDX_W'(DEPTH - 1)) begin
              // Word 15 lands this edge; slot 0 never maps to it, so the
              // registered read of the old buffer contents is safe.
              r_state     <= ST_DRAIN;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_idx   <= '0;
              r_out_word  <= r_buf[w_rd_sel];
            end
          end
        end
        ST_DRAIN: begin
          if (out_ready_i) begin
            r_count <= w_next_count;
            if (r_count == IDX_W'(DEPTH - 1)) begin
              r_state     <= ST_LOAD;
              r_in_ready  <= 1'b1;
              r_out_valid <= 1'b0;
              r_out_idx   <= '0;
              r_out_word  <= '0;
            end else begin
              r_out_idx  <= w_next_count;
              r_out_word <= r_buf[w_rd_sel];
            end
          end
        end
        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign out_word_o  = r_out_word;
  assign out_idx_o   = r_out_idx;

endmodule

// File: doc/inv_permute_buffer.md
INV_PERMUTE_BUFFER -- requirements
Module: inv_permute_buffer

Interface
REQ-001 SHALL have parameter WORD_W, default 64, data word width in bits.
REQ-002 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid_i  input  1  input word offered.
REQ-005 SHALL have port in_ready_o  output  1  input word accepted when in_valid_i and in_ready_o are both high.
REQ-006 SHALL have port in_word_i  input  WORD_W  permuted-domain word; arrival order is word index 0..15.
REQ-007 SHALL have port out_valid_o  output  1  output word presented.
REQ-008 SHALL have port out_ready_i  input  1  output word consumed when out_valid_o and out_ready_i are both high.
REQ-009 SHALL have port out_word_o  output  WORD_W  unpermuted word.
REQ-010 SHALL have port out_idx_o  output  4  index 0..15 of the word on out_word_o.

Function
REQ-011 SHALL implement the inverse of the Threefish-1024 word permutation: output word j = input word INV[j].
  - INV = 0,15,2,11,6,13,4,9,14,1,8,5,10,3,12,7.
REQ-012 SHALL hold a 16 x WORD_W buffer and a 4-bit count, and SHALL have two states: LOAD and DRAIN.
REQ-013 In LOAD, in_ready_o SHALL be 1 and out_valid_o SHALL be 0.
  - Each input handshake writes buffer[count] and increments count.
REQ-014 On the 16th input handshake (count=15), the block SHALL wrap count to 0 and enter DRAIN on the next cycle.
  - out_valid_o rises exactly one cycle after the 16th acceptance.
REQ-015 In DRAIN, in_ready_o SHALL be 0, out_valid_o SHALL be 1, out_idx_o SHALL equal count, and out_word_o SHALL equal buffer[INV[count]].
REQ-016 In DRAIN, each output handshake SHALL increment count.
  - With out_ready_i low, out_word_o and out_idx_o hold stable.
REQ-017 On the output handshake at count=15, the block SHALL wrap count to 0 and return to LOAD.
  - in_ready_o rises the next cycle; no input is accepted in the cycle of the last output handshake.
REQ-018 in_valid_i SHALL be ignored in DRAIN.
REQ-019 out_ready_i SHALL be ignored in LOAD.
REQ-020 When out_valid_o is 0, out_word_o SHALL be driven to all-zeros and out_idx_o to 0.
REQ-021 Sustained throughput SHALL be 16 words in, then 16 words out: 32 cycles per block with no stalls.

Reset
REQ-022 While rst_i is high at a clock edge, the block SHALL enter LOAD with count=0, in_ready_o=1, out_valid_o=0, out_word_o=0 and out_idx_o=0.
REQ-023 Reset SHALL NOT clear the buffer contents.
  - Stale contents are never visible, because DRAIN is reachable only after 16 fresh writes.
REQ-024 Reset asserted mid-LOAD or mid-DRAIN SHALL discard the partial block.
  - The next accepted word is index 0.

Configuration
REQ-025 When macro INV_PERMUTE_FWD_EN is defined, the block SHALL add port dir_i  input  1, sampled at the first input handshake of each block and held for that block.
  - dir_i=1 selects the forward permutation PI = 0,9,2,13,6,11,4,15,10,7,12,3,14,5,8,1.
  - dir_i=0 selects INV.
REQ-026 When INV_PERMUTE_FWD_EN is undefined, there SHALL be no dir_i port and INV SHALL always apply.
  - All other behaviour is identical to the defined case.

Verification
REQ-027 Load words 0..15 with in_valid_i held high and out_ready_i held high -> out_word_o sequence 0,15,2,11,6,13,4,9,14,1,8,5,10,3,12,7, with out_idx_o 0..15 and out_valid_o first high 1 cycle after the 16th acceptance.
REQ-028 Same load, then toggle out_ready_i every cycle during DRAIN -> identical sequence, each word held stable while out_ready_i=0, DRAIN lasting 32 cycles.
REQ-029 Pulse rst_i after 7 words are accepted, then load words 100..115 -> outputs 100,115,102,111,106,113,104,109,114,101,108,105,110,103,112,107.
REQ-030 Run two back-to-back blocks with in_valid_i held high -> in_ready_o low for exactly 16 cycles between blocks, and the second block's output correct.
REQ-031 With INV_PERMUTE_FWD_EN defined and dir_i=1, load 0..15 -> outputs 0,9,2,13,6,11,4,15,10,7,12,3,14,5,8,1; feeding those outputs back in with dir_i=0 -> outputs 0..15.
